// File: rtl/mul_8bits_seq.sv
// ---------------------------------------------------------------------------
// mul_8bits_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier. One 8-bit ripple adder
// is reused for eight iterations to build a 16-bit product, with a
// start/busy/done handshake for the ALU.
//
// Modules in this file:
//   adder_8bits   : combinational 8-bit adder with carry in/out
//   mul_8bits_seq : multiplier controller (top)
//
// mul_8bits_seq ports:
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous active-high reset
//   start in   1   multiply request, sampled on rising clk
//   A     in   8   multiplicand, captured on an accepted start
//   B     in   8   multiplier, captured on an accepted start
//   busy  out  1   high while iterating
//   done  out  1   product valid (1-cycle pulse, or held when HOLD_DONE=1)
//   P     out  16  product {H,L}; holds its value after completion
// ---------------------------------------------------------------------------

module adder_8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  // Widen both operands so the carry out falls into bit 8
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

module mul_8bits_seq #(
  parameter int HOLD_DONE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] P
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] m;
  logic [7:0] h;
  logic [7:0] l;
  logic [2:0] cnt;

  logic [7:0] addend;
  logic [7:0] sum;
  logic       carry;

  // Partial product for this iteration: add the multiplicand only when the
  // current low multiplier bit is set
  assign addend = l[0] ? m : 8'h00;

  adder_8bits u_adder (
    .A    (h),
    .B    (addend),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (carry)
  );

  // Control and datapath registers. A new request is taken in IDLE and in
  // DONE so back-to-back multiplies run without an idle bubble; requests
  // arriving while iterating are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= 8'h00;
      h     <= 8'h00;
      l     <= 8'h00;
      cnt   <= 3'd0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= A;
            h     <= 8'h00;
            l     <= B;
            cnt   <= 3'd0;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // 17-bit {carry,sum,l} shifted right by one: the carry becomes
          // the top accumulator bit and the consumed multiplier bit drops out
          {h, l} <= {carry, sum, l[7:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            m     <= A;
            h     <= 8'h00;
            l     <= B;
            cnt   <= 3'd0;
            done  <= 1'b0;
            state <= RUN;
          end else if (HOLD_DONE == 0) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign P    = {h, l};

endmodule

// File: tb/tb_mul_8bits_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_8bits_seq.sv
// Self-checking bench for mul_8bits_seq. Two instances are built: dut0 with
// a one-cycle done pulse and dut1 with a held done. Expected products come
// from plain 16-bit multiplication of the operands.
// ---------------------------------------------------------------------------

module tb_mul_8bits_seq;

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  a0, b0, a1, b1;
  logic        busy0, done0, busy1, done1;
  logic [15:0] p0, p1;

  logic        sel;
  logic        busyS, doneS;
  logic [15:0] pS;

  int checkCount;
  int passCount;
  int failCount;

  mul_8bits_seq #(.HOLD_DONE(0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .A     (a0),
    .B     (b0),
    .busy  (busy0),
    .done  (done0),
    .P     (p0)
  );

  mul_8bits_seq #(.HOLD_DONE(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .busy  (busy1),
    .done  (done1),
    .P     (p1)
  );

  // Outputs of whichever instance the current step is exercising
  assign busyS = sel ? busy1 : busy0;
  assign doneS = sel ? done1 : done0;
  assign pS    = sel ? p1 : p0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      start1 = v;
      if (v) begin a1 = a; b1 = b; end
    end else begin
      start0 = v;
      if (v) begin a0 = a; b0 = b; end
    end
  endtask

  // Raise start for exactly one rising edge; returns in the first RUN cycle
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    setStart(1'b1, a, b);
    @(negedge clk);
    setStart(1'b0, 8'h00, 8'h00);
  endtask

  // Walks the eight busy cycles and checks the done cycle. A nonzero
  // intrude raises a competing start during that RUN cycle, which the
  // model expects to be ignored. Returns while still in the done cycle.
  task automatic runChecks(input logic [7:0] a, input logic [7:0] b,
                           input int intrude, input string tag);
    logic [15:0] expected;
    expected = 16'(a) * 16'(b);
    for (int c = 1; c <= 8; c++) begin
      checkOutput({tag, "_busy"}, {15'b0, busyS}, 16'd1);
      checkOutput({tag, "_donelow"}, {15'b0, doneS}, 16'd0);
      if (c == intrude)
        setStart(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        setStart(1'b0, 8'h00, 8'h00);
      @(negedge clk);
    end
    setStart(1'b0, 8'h00, 8'h00);
    checkOutput({tag, "_done"}, {15'b0, doneS}, 16'd1);
    checkOutput({tag, "_busyend"}, {15'b0, busyS}, 16'd0);
    checkOutput({tag, "_P"}, pS, expected);
  endtask

  // After a pulsed done, the next cycle must be idle with the product held
  task automatic checkIdleAfter(input logic [7:0] a, input logic [7:0] b,
                                input string tag);
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, {15'b0, doneS}, 16'd0);
    checkOutput({tag, "_idlebusy"}, {15'b0, busyS}, 16'd0);
    checkOutput({tag, "_Phold"}, pS, 16'(a) * 16'(b));
  endtask

  initial begin
    logic [7:0] ra, rb;
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    sel    = 1'b0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00;
    a1 = 8'h00; b1 = 8'h00;

    $display("[TB] reset checks");
    #2;
    checkOutput("rst_busy", {15'b0, busy0}, 16'd0);
    checkOutput("rst_done", {15'b0, done0}, 16'd0);
    checkOutput("rst_P", p0, 16'h0000);
    checkOutput("rst_done_hold", {15'b0, done1}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed products");
    applyStimulus(8'd13, 8'd11);
    runChecks(8'd13, 8'd11, 0, "m13x11");
    checkOutput("m13x11_const", pS, 16'h008F);
    checkIdleAfter(8'd13, 8'd11, "m13x11");

    applyStimulus(8'd255, 8'd255);
    runChecks(8'd255, 8'd255, 0, "m255x255");
    checkOutput("m255x255_const", pS, 16'hFE01);
    checkIdleAfter(8'd255, 8'd255, "m255x255");

    applyStimulus(8'd0, 8'd200);
    runChecks(8'd0, 8'd200, 0, "m0x200");
    applyStimulus(8'd200, 8'd1);
    runChecks(8'd200, 8'd1, 0, "m200x1");
    checkOutput("m200x1_const", pS, 16'h00C8);
    applyStimulus(8'd1, 8'd0);
    runChecks(8'd1, 8'd0, 0, "m1x0");

    $display("[TB] start during RUN is ignored");
    applyStimulus(8'd13, 8'd11);
    checkOutput("ign_c1", {15'b0, busyS}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    setStart(1'b1, 8'd2, 8'd2);
    @(negedge clk);
    setStart(1'b0, 8'h00, 8'h00);
    for (int c = 4; c <= 8; c++) @(negedge clk);
    checkOutput("ign_done", {15'b0, doneS}, 16'd1);
    checkOutput("ign_P", pS, 16'h008F);
    checkIdleAfter(8'd13, 8'd11, "ign");

    $display("[TB] back-to-back");
    applyStimulus(8'd13, 8'd11);
    runChecks(8'd13, 8'd11, 0, "b2b_first");
    setStart(1'b1, 8'd16, 8'd16);
    checkOutput("b2b_first_P143", pS, 16'd143);
    @(negedge clk);
    setStart(1'b0, 8'h00, 8'h00);
    runChecks(8'd16, 8'd16, 0, "b2b_second");
    checkOutput("b2b_second_const", pS, 16'h0100);
    checkIdleAfter(8'd16, 8'd16, "b2b_second");

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(8'd100, 8'd100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("arst_prebusy", {15'b0, busyS}, 16'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {15'b0, busy0}, 16'd0);
    checkOutput("arst_done", {15'b0, done0}, 16'd0);
    checkOutput("arst_P", p0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("arst_idle_busy", {15'b0, busy0}, 16'd0);
    checkOutput("arst_idle_P", p0, 16'h0000);
    applyStimulus(8'd3, 8'd5);
    runChecks(8'd3, 8'd5, 0, "arst_after");
    checkOutput("arst_after_const", pS, 16'h000F);
    checkIdleAfter(8'd3, 8'd5, "arst_after");

    $display("[TB] randomized products");
    for (int n = 0; n < 12; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb);
      runChecks(ra, rb, int'($urandom_range(0, 8)), "rand");
      checkIdleAfter(ra, rb, "rand");
    end

    $display("[TB] held done");
    sel = 1'b1;
    applyStimulus(8'd7, 8'd9);
    runChecks(8'd7, 8'd9, 0, "hold");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("hold_done", {15'b0, doneS}, 16'd1);
      checkOutput("hold_P", pS, 16'h003F);
    end
    checkOutput("hold_busy", {15'b0, busyS}, 16'd0);
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    applyStimulus(ra, rb);
    runChecks(ra, rb, 0, "hold_next");
    @(negedge clk);
    checkOutput("hold_next_stay", {15'b0, doneS}, 16'd1);
    checkOutput("hold_next_P", pS, 16'(ra) * 16'(rb));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mul_8bits_seq.md
Name: mul_8bits_seq

Overview:
Sequential 8x8 unsigned shift-and-add multiplier controller. It sequences one adder_8bits instance (Cin tied 0) over 8 iterations to form a 16-bit product, and exposes a start/busy/done handshake. It sits in the arithmetic unit alongside the combinational adder and gives the ALU a multiply operation without a second adder.

Parameters:
HOLD_DONE, 0, 0 = done is a 1-cycle pulse; 1 = done stays high until the next accepted start or reset.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on rising clk edge.
A  input  8  multiplicand, captured on accepted start.
B  input  8  multiplier, captured on accepted start.
busy  output  1  high while iterating (RUN state).
done  output  1  product valid strobe (see HOLD_DONE).
P  output  16  product {H,L}; holds value after completion.

Behaviour:
- Registers: M[7:0] (multiplicand), H[7:0] (accumulator), L[7:0] (multiplier/low product), cnt[2:0], state.
- States: IDLE, RUN, DONE.
- Reset (async, any time including mid-RUN): state=IDLE, M=H=L=0, cnt=0, busy=0, done=0, P=16'h0000.
- Accepted start: start=1 at an edge while state is IDLE or DONE. Effect: M<=A, H<=0, L<=B, cnt<=0, state<=RUN, done<=0.
- start while in RUN: ignored. Operands and iteration are unaffected.
- Adder hookup (combinational): adder A input = H, B input = L[0] ? M : 8'h00, Cin = 0, outputs S and Cout.
- RUN, each edge: {H,L} <= {Cout, S, L[7:1]}, i.e. a 17-bit {Cout,S,L} right shift by 1; cnt <= cnt+1.
- RUN with cnt==7: perform the final step, then state<=DONE.
- Latency: start accepted at edge 0; iterations at edges 1..8; done=1 and the final P are visible after edge 8. That is 8 busy cycles, with done valid in the 9th cycle after the start edge.
- busy = (state==RUN). P = {H,L} at all times. P is intermediate during RUN and valid only when done=1.
- DONE:
  - HOLD_DONE=0: done=1 for exactly one cycle, then state<=IDLE.
  - HOLD_DONE=1: remains in DONE with done=1 until an accepted start.
  - P holds its value in both cases.
- start in the DONE cycle: accepted (back-to-back). done drops next cycle, RUN begins, and no idle bubble is inserted.
- Arithmetic: unsigned only. The product is at most 0xFE01, so no overflow is possible. Cout of the final iteration lands in P[15].
- No combinational path from start to any output. All outputs are registered or decoded from state.

Test Plan:
- Reset, then A=13, B=11, pulse start: busy high for 8 cycles; done high in the 9th cycle; P=16'h008F; with HOLD_DONE=0, done low the following cycle.
- A=255, B=255: P=16'hFE01 at done. A=0, B=200: P=0. A=200, B=1: P=16'h00C8. A=1, B=0: P=0.
- Start A=13, B=11, then at cycle 3 of RUN raise start with A=2, B=2: the second request is ignored and P=16'h008F at the original done cycle.
- Back-to-back: start asserted in the done cycle with A=16, B=16: the first result (143) is visible during done; the second done arrives 9 cycles later with P=16'h0100.
- Assert rst during RUN cycle 4 (A=100, B=100): busy, done and P clear immediately (asynchronous). After rst release, state=IDLE, and a new start with A=3, B=5 yields P=16'h000F.
- HOLD_DONE=1, A=7, B=9: done stays high and P=16'h003F holds for 20 idle cycles. The next start clears done on the following cycle.
